pixel_array_controller: RTL and testbench

PIXEL_ARRAY_CONTROLLER -- requirements
Module: pixel_array_controller

---
 rtl/pixel_array_controller.sv | 114 +++++++++++
 tb/tb_pixel_array_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_controller.sv
// pixel_array_controller: frame sequencer for a pixel array (erase, expose, per-row ADC reset/convert/readout)
// Ports: clk, reset (async active-low), start/abort/continuous control levels, expose_time (latched per frame),
//        row_done from the array; registered Moore outputs ERASE, EXPOSE, adc_reset, adc_enable, decoder_select,
//        row_strobe, frame_done, busy, timeout_err (sticky until the next frame start).
module pixel_array_controller #(
  parameter int ROWS         = 3,
  parameter int WIDTH        = 2,
  parameter int ERASE_CYCLES = 4,
  parameter int CONV_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [15:0]      expose_time,
  input  logic             row_done,
  output logic             ERASE,
  output logic             EXPOSE,
  output logic             adc_reset,
  output logic             adc_enable,
  output logic [WIDTH-1:0] decoder_select,
  output logic             row_strobe,
  output logic             frame_done,
  output logic             busy,
  output logic             timeout_err
);
  typedef enum logic [2:0] {IDLE, ERASE_S, EXPOSE_S, ROW_RST, ROW_CONV, ROW_NEXT, FRAME_DONE} state_t;
  state_t state, nxt;
  logic [15:0] cnt, exp_q, exp_d, exp_len;
  logic [WIDTH-1:0] row, row_d;
  logic row_done_q, rise, tmo, strobe_d, terr_d;
  assign exp_len = exp_q == 16'd0 ? 16'd1 : exp_q;
  // only a fresh rising edge ends a conversion; a level held over from the previous row is ignored
  assign rise = row_done && !row_done_q;
  assign tmo = cnt == 16'(CONV_TIMEOUT - 1);
  always_comb begin
    nxt = state;
    row_d = row;
    exp_d = exp_q;
    strobe_d = 1'b0;
    terr_d = timeout_err;
    case (state)
      IDLE: if (start) begin
        nxt = ERASE_S;
        row_d = '0;
        exp_d = expose_time;
        terr_d = 1'b0;
      end
      ERASE_S: if (cnt == 16'(ERASE_CYCLES - 1)) nxt = EXPOSE_S;
      EXPOSE_S: if (cnt == exp_len - 16'd1) nxt = ROW_RST;
      ROW_RST: nxt = ROW_CONV;
      ROW_CONV: if (rise) begin
        nxt = ROW_NEXT;
        strobe_d = 1'b1;
      end else if (tmo) begin
        nxt = ROW_NEXT;
        terr_d = 1'b1;
      end
      ROW_NEXT: if (row == WIDTH'(ROWS - 1)) nxt = FRAME_DONE;
      else begin
        nxt = ROW_RST;
        row_d = row + 1'b1;
      end
      FRAME_DONE: if (continuous) begin
        nxt = ERASE_S;
        row_d = '0;
        exp_d = expose_time;
        terr_d = 1'b0;
      end else nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over a same-cycle row_done edge or timeout
    if (abort && state != IDLE) begin
      nxt = IDLE;
      strobe_d = 1'b0;
      terr_d = timeout_err;
    end
  end
  // outputs are decoded from the next state so they are registered yet aligned with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      row <= '0;
      exp_q <= '0;
      row_done_q <= 1'b0;
      ERASE <= 1'b0;
      EXPOSE <= 1'b0;
      adc_reset <= 1'b0;
      adc_enable <= 1'b0;
      decoder_select <= '0;
      row_strobe <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : (&cnt ? cnt : cnt + 1'b1);
      row <= row_d;
      exp_q <= exp_d;
      row_done_q <= row_done;
      ERASE <= nxt == ERASE_S;
      EXPOSE <= nxt == EXPOSE_S;
      adc_reset <= nxt == ROW_RST;
      adc_enable <= nxt == ROW_CONV;
      decoder_select <= (nxt == ROW_RST || nxt == ROW_CONV || nxt == ROW_NEXT) ? row_d : '0;
      row_strobe <= strobe_d;
      frame_done <= nxt == FRAME_DONE;
      busy <= nxt != IDLE;
      timeout_err <= terr_d;
    end
  end
endmodule

// File: tb/tb_pixel_array_controller.sv
// tb_pixel_array_controller: directed checks of the pixel array frame sequencer
module tb_pixel_array_controller;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, continuous = 1'b0, row_done = 1'b0;
  logic [15:0] expose_time = 16'd0;
  logic ERASE, EXPOSE, adc_reset, adc_enable, row_strobe, frame_done, busy, timeout_err;
  logic [1:0] decoder_select;
  int n_checks = 0, n_fail = 0;
  int n_er, n_ex, n_ar, n_st, n_fd, n_ov, sel_seq;
  logic ok;

  pixel_array_controller dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .expose_time(expose_time), .row_done(row_done), .ERASE(ERASE), .EXPOSE(EXPOSE),
    .adc_reset(adc_reset), .adc_enable(adc_enable), .decoder_select(decoder_select),
    .row_strobe(row_strobe), .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st;
    logic rd;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [9:0] outs();
    return {ERASE, EXPOSE, adc_reset, adc_enable, decoder_select, row_strobe, frame_done, busy, timeout_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // runs one frame with a row_done responder that withholds the edge on row skip
  task automatic run_frame(input logic [1:0] skip, input int limit);
    n_er = 0; n_ex = 0; n_ar = 0; n_st = 0; n_fd = 0; n_ov = 0; sel_seq = 0; ok = 1'b0;
    start = 1'b1;
    for (int c = 0; c < limit; c++) begin
      step();
      start = 1'b0;
      n_er += int'(ERASE);
      n_ex += int'(EXPOSE);
      n_ar += int'(adc_reset);
      n_st += int'(row_strobe);
      n_fd += int'(frame_done);
      n_ov += int'(ERASE & EXPOSE);
      if (adc_reset) sel_seq = sel_seq * 4 + int'(decoder_select);
      row_done = adc_enable && decoder_select != skip;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    row_done = 1'b0;
    check("frame_end", 32'(ok), 32'd1);
  endtask

  initial begin
    // E X R N sel S F B T ; expose_time 0, start pulse, start again mid-readout, row_done held over rows
    tbl[0]  = '{1'b1, 1'b0, 10'b1000000010};
    tbl[1]  = '{1'b0, 1'b0, 10'b1000000010};
    tbl[2]  = '{1'b0, 1'b0, 10'b1000000010};
    tbl[3]  = '{1'b0, 1'b0, 10'b1000000010};
    tbl[4]  = '{1'b0, 1'b0, 10'b0100000010};
    tbl[5]  = '{1'b0, 1'b0, 10'b0010000010};
    tbl[6]  = '{1'b0, 1'b0, 10'b0001000010};
    tbl[7]  = '{1'b0, 1'b1, 10'b0000001010};
    tbl[8]  = '{1'b0, 1'b0, 10'b0010010010};
    tbl[9]  = '{1'b1, 1'b0, 10'b0001010010};
    tbl[10] = '{1'b0, 1'b1, 10'b0000011010};
    tbl[11] = '{1'b0, 1'b1, 10'b0010100010};
    tbl[12] = '{1'b0, 1'b1, 10'b0001100010};
    tbl[13] = '{1'b0, 1'b1, 10'b0001100010};
    tbl[14] = '{1'b0, 1'b0, 10'b0001100010};
    tbl[15] = '{1'b0, 1'b1, 10'b0000101010};
    tbl[16] = '{1'b0, 1'b0, 10'b0000000110};
    tbl[17] = '{1'b0, 1'b0, 10'b0000000000};
    #12;
    check("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st;
      row_done = tbl[i].rd;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    start = 1'b0;
    row_done = 1'b0;
    step();
    // nominal frame, expose_time 10
    expose_time = 16'd10;
    run_frame(2'd3, 300);
    check("erase_cycles", 32'(n_er), 32'd4);
    check("expose_cycles", 32'(n_ex), 32'd10);
    check("overlap", 32'(n_ov), 32'd0);
    check("adc_resets", 32'(n_ar), 32'd3);
    check("row_order", 32'(sel_seq), 32'd6);
    check("row_strobes", 32'(n_st), 32'd3);
    check("frame_dones", 32'(n_fd), 32'd1);
    // row 1 never converts: timeout, row 2 still read
    expose_time = 16'd0;
    run_frame(2'd1, 2000);
    check("to_strobes", 32'(n_st), 32'd2);
    check("to_resets", 32'(n_ar), 32'd3);
    check("to_frame_done", 32'(n_fd), 32'd1);
    check("to_err_set", 32'(timeout_err), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("to_err_clear", 32'({timeout_err, ERASE}), 32'b01);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_erase", 32'(outs()), 32'd0);
    // continuous restart then abort during exposure
    continuous = 1'b1;
    ok = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      start = 1'b0;
      row_done = adc_enable;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("cont_fd_seen", 32'(ok), 32'd1);
    row_done = 1'b0;
    expose_time = 16'd10;
    step();
    continuous = 1'b0;
    check("cont_restart", 32'(outs()), 32'b1000000010);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (EXPOSE) begin
        ok = 1'b1;
        break;
      end
    end
    check("expose_seen", 32'(ok), 32'd1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_expose", 32'(outs()), 32'd0);
    step();
    check("abort_no_fd", 32'({frame_done, busy}), 32'd0);
    // asynchronous reset during ROW_CONV of row 1
    expose_time = 16'd0;
    ok = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      start = 1'b0;
      if (adc_enable && decoder_select == 2'd1) begin
        ok = 1'b1;
        break;
      end
      row_done = adc_enable;
    end
    row_done = 1'b0;
    check("row1_conv_seen", 32'(ok), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'd0);
    step();
    #2 reset = 1'b1;
    for (int c = 0; c < 5; c++) step();
    check("idle_after_reset", 32'(outs()), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_after_reset", 32'(outs()), 32'b1000000010);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
